sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 176 +++++++++++++++++
 tb/tb_sdram_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// Behavioural SDR SDRAM target: decodes controller commands, checks init/bank/timing
// protocol, and serves reads and writes from a word-wide backing store.
module sdram_responder #(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned TRCD   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sd_cs_n,
  input  logic        sd_ras_n,
  input  logic        sd_cas_n,
  input  logic        sd_we_n,
  input  logic [1:0]  sd_ba,
  input  logic [10:0] sd_a,
  input  logic [3:0]  sd_dqm,
  input  logic [31:0] sd_dq_in,
  output logic [31:0] sd_dq_out,
  output logic        sd_dq_oe,
  output logic        ready,
  output logic [4:0]  err,
  output logic [15:0] refresh_cnt
);

  localparam int unsigned DEPTH    = 32'(1) << MEM_AW;
  localparam int unsigned NBANK    = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned PIPE_W   = 33;

  typedef enum logic [1:0] {
    ST_UNINIT     = 2'd0,
    ST_PRECHARGED = 2'd1,
    ST_READY      = 2'd2
  } init_state_t;

  init_state_t        state;
  logic [NBANK-1:0]   bank_open;
  logic [10:0]        bank_row [NBANK];
  logic [CNT_W-1:0]   bank_cnt [NBANK];
  logic [2:0]         cl;
  logic [PIPE_W-1:0]  pipe [2];
  logic [31:0]        mem [DEPTH];

  logic              cmd_act_c, cmd_rd_c, cmd_wr_c, cmd_pre_c, cmd_ref_c, cmd_lmr_c;
  logic              is_ready_c;
  logic              sel_open_c;
  logic              too_early_c;
  logic              cl_valid_c;
  logic [MEM_AW-1:0] addr_c;
  logic [31:0]       rd_data_c;

  // Command decode, qualified by chip select
  always_comb begin
    cmd_act_c = 1'b0;
    cmd_rd_c  = 1'b0;
    cmd_wr_c  = 1'b0;
    cmd_pre_c = 1'b0;
    cmd_ref_c = 1'b0;
    cmd_lmr_c = 1'b0;
    if (!sd_cs_n) begin
      case ({sd_ras_n, sd_cas_n, sd_we_n})
        3'b011:  cmd_act_c = 1'b1;
        3'b101:  cmd_rd_c  = 1'b1;
        3'b100:  cmd_wr_c  = 1'b1;
        3'b010:  cmd_pre_c = 1'b1;
        3'b001:  cmd_ref_c = 1'b1;
        3'b000:  cmd_lmr_c = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    is_ready_c  = (state == ST_READY);
    sel_open_c  = bank_open[sd_ba];
    too_early_c = ({29'd0, bank_cnt[sd_ba]} < TRCD);
    cl_valid_c  = ((sd_a[6:4] == 3'd2) || (sd_a[6:4] == 3'd3)) && (sd_a[2:0] == 3'd0);
    // Full {bank,row,col} address folded onto the store; aliasing is deliberate
    addr_c      = MEM_AW'({sd_ba, bank_row[sd_ba], sd_a[7:0]});
  end

  // Read word with DQM-masked lanes forced to zero
  always_comb begin
    rd_data_c = mem[addr_c];
    for (int i = 0; i < 4; i++) begin
      if (sd_dqm[i]) rd_data_c[8*i +: 8] = 8'h00;
    end
  end

  // Backing store: no reset, byte-lane write enables
  always_ff @(posedge clk) begin
    if (cmd_wr_c && is_ready_c && sel_open_c) begin
      for (int i = 0; i < 4; i++) begin
        if (!sd_dqm[i]) mem[addr_c][8*i +: 8] <= sd_dq_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_UNINIT;
      ready       <= 1'b0;
      bank_open   <= '0;
      for (int b = 0; b < NBANK; b++) begin
        bank_row[b] <= '0;
        bank_cnt[b] <= '0;
      end
      cl          <= 3'd2;
      pipe[0]     <= '0;
      pipe[1]     <= '0;
      sd_dq_oe    <= 1'b0;
      sd_dq_out   <= '0;
      err         <= '0;
      refresh_cnt <= '0;
    end else begin
      for (int b = 0; b < NBANK; b++) begin
        if (bank_cnt[b] != {CNT_W{1'b1}}) bank_cnt[b] <= bank_cnt[b] + CNT_W'(1);
      end

      // Read pipeline drains toward the output register; READ enters at depth CL-1
      pipe[0]   <= pipe[1];
      pipe[1]   <= '0;
      sd_dq_oe  <= pipe[0][32];
      sd_dq_out <= pipe[0][32] ? pipe[0][31:0] : 32'd0;

      if (cmd_act_c) begin
        if (!is_ready_c) begin
          err[0] <= 1'b1;
        end else begin
          if (sel_open_c) err[2] <= 1'b1;
          bank_open[sd_ba] <= 1'b1;
          bank_row[sd_ba]  <= sd_a;
          bank_cnt[sd_ba]  <= '0;
        end
      end

      if (cmd_rd_c || cmd_wr_c) begin
        if (!is_ready_c) begin
          err[0] <= 1'b1;
        end else if (!sel_open_c) begin
          err[2] <= 1'b1;
        end else begin
          if (too_early_c) err[3] <= 1'b1;
          if (cmd_rd_c) begin
            if (cl == 3'd3) pipe[1] <= {1'b1, rd_data_c};
            else            pipe[0] <= {1'b1, rd_data_c};
          end
          if (sd_a[10]) bank_open[sd_ba] <= 1'b0;
        end
      end

      if (cmd_pre_c) begin
        if (sd_a[10]) begin
          bank_open <= '0;
          if (state == ST_UNINIT) state <= ST_PRECHARGED;
        end else begin
          bank_open[sd_ba] <= 1'b0;
        end
      end

      if (cmd_ref_c) begin
        if (|bank_open) err[4] <= 1'b1;
        if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
      end

      if (cmd_lmr_c) begin
        if (cl_valid_c) cl <= sd_a[6:4];
        else            err[1] <= 1'b1;
        if (state == ST_PRECHARGED) begin
          state <= ST_READY;
          ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: read beats are predicted into a scoreboard
// when a READ is issued and matched against sd_dq_oe/sd_dq_out by a monitor.
module tb_sdram_responder;

  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  logic        clk;
  logic        reset_n;
  logic        sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n;
  logic [1:0]  sd_ba;
  logic [10:0] sd_a;
  logic [3:0]  sd_dqm;
  logic [31:0] sd_dq_in;
  logic [31:0] sd_dq_out;
  logic        sd_dq_oe;
  logic        ready;
  logic [4:0]  err;
  logic [15:0] refresh_cnt;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks   = 0;
  int          failures = 0;
  int unsigned edge_cnt = 0;
  int unsigned cl_model = 2;

  sdram_responder #(.MEM_AW(10), .TRCD(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sd_cs_n    (sd_cs_n),
    .sd_ras_n   (sd_ras_n),
    .sd_cas_n   (sd_cas_n),
    .sd_we_n    (sd_we_n),
    .sd_ba      (sd_ba),
    .sd_a       (sd_a),
    .sd_dqm     (sd_dqm),
    .sd_dq_in   (sd_dq_in),
    .sd_dq_out  (sd_dq_out),
    .sd_dq_oe   (sd_dq_oe),
    .ready      (ready),
    .err        (err),
    .refresh_cnt(refresh_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // The value seen at the negedge after edge N+CL-1 is what edge N+CL samples
  always @(negedge clk) begin
    if (sd_dq_oe) begin
      if (sb.size() == 0) begin
        chk("spurious_oe", 32'(sd_dq_oe), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", sd_dq_out, mon_e.data);
        chk("rd_latency", edge_cnt, mon_e.due);
      end
    end else begin
      chk("dq_idle_zero", sd_dq_out, 32'd0);
      if (sb.size() != 0 && sb[0].due <= edge_cnt) begin
        mon_e = sb.pop_front();
        chk("rd_missing_oe", 32'(sd_dq_oe), 32'd1);
      end
    end
  end

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [10:0] a,
                     input logic [3:0] dqm, input logic [31:0] dq);
    sd_cs_n = 1'b0;
    {sd_ras_n, sd_cas_n, sd_we_n} = c;
    sd_ba = ba; sd_a = a; sd_dqm = dqm; sd_dq_in = dq;
    @(posedge clk);
    @(negedge clk);
    sd_cs_n = 1'b1;
    {sd_ras_n, sd_cas_n, sd_we_n} = 3'b111;
  endtask

  task automatic nop(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] ba, input logic [10:0] a, input logic [3:0] dqm,
                    input logic [31:0] exp);
    exp_t e;
    e.due  = edge_cnt + cl_model;
    e.data = exp;
    sb.push_back(e);
    cmd(C_RD, ba, a, dqm, 32'd0);
  endtask

  task automatic init_seq();
    cmd(C_PRE, 2'd0, 11'h400, 4'd0, 32'd0);
    cmd(C_LMR, 2'd0, 11'h220, 4'd0, 32'd0);
    cl_model = 2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sb.delete();
    cl_model = 2;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    sd_cs_n = 1'b1;
    {sd_ras_n, sd_cas_n, sd_we_n} = 3'b111;
    sd_ba = '0; sd_a = '0; sd_dqm = '0; sd_dq_in = '0;
    repeat (2) @(negedge clk);

    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_refresh", 32'(refresh_cnt), 32'd0);
    chk("rst_oe", 32'(sd_dq_oe), 32'd0);
    reset_n = 1'b1;

    init_seq();
    chk("init_ready", 32'(ready), 32'd1);
    chk("init_err", 32'(err), 32'd0);

    // Pre-init accesses and LOAD_MODE while uninitialised
    do_reset();
    cmd(C_LMR, 2'd0, 11'h220, 4'd0, 32'd0);
    chk("lmr_uninit_ready", 32'(ready), 32'd0);
    cmd(C_PRE, 2'd0, 11'h400, 4'd0, 32'd0);
    chk("precharged_ready", 32'(ready), 32'd0);
    cmd(C_RD, 2'd0, 11'h000, 4'd0, 32'd0);
    nop(4);
    chk("rd_before_ready_err", 32'(err), 32'h01);

    // Basic write/read at CL=2, masks, back-to-back and write during flight
    do_reset();
    init_seq();
    cmd(C_ACT, 2'd1, 11'd5, 4'd0, 32'd0);
    nop(3);
    cmd(C_WR, 2'd1, 11'h012, 4'd0, 32'hDEADBEEF);
    rd(2'd1, 11'h012, 4'd0, 32'hDEADBEEF);
    nop(4);
    chk("wr_rd_err", 32'(err), 32'd0);
    cmd(C_WR, 2'd1, 11'h020, 4'b0000, 32'hAABBCCDD);
    cmd(C_WR, 2'd1, 11'h020, 4'b0011, 32'h11223344);
    rd(2'd1, 11'h020, 4'b0000, 32'h1122CCDD);
    rd(2'd1, 11'h020, 4'b1100, 32'h0000CCDD);
    rd(2'd1, 11'h012, 4'b0000, 32'hDEADBEEF);
    cmd(C_WR, 2'd1, 11'h030, 4'b0000, 32'h0BADF00D);
    rd(2'd1, 11'h030, 4'b0000, 32'h0BADF00D);
    nop(4);
    chk("mask_err", 32'(err), 32'd0);

    // tRCD violation still accesses; closed-bank read; refresh with open banks
    cmd(C_ACT, 2'd2, 11'd7, 4'd0, 32'd0);
    cmd(C_WR, 2'd2, 11'h001, 4'd0, 32'h13572468);
    rd(2'd2, 11'h001, 4'd0, 32'h13572468);
    nop(4);
    chk("trcd_err", 32'(err), 32'h08);
    cmd(C_RD, 2'd3, 11'h001, 4'd0, 32'd0);
    nop(4);
    chk("closed_bank_err", 32'(err), 32'h0C);
    cmd(C_REF, 2'd0, 11'h000, 4'd0, 32'd0);
    chk("refresh_open_err", 32'(err), 32'h1C);
    chk("refresh_cnt", 32'(refresh_cnt), 32'd1);

    // CL=3, then an illegal mode that must keep CL=3
    cmd(C_LMR, 2'd0, 11'h230, 4'd0, 32'd0);
    cl_model = 3;
    rd(2'd1, 11'h012, 4'd0, 32'hDEADBEEF);
    nop(5);
    chk("cl3_err", 32'(err), 32'h1C);
    cmd(C_LMR, 2'd0, 11'h240, 4'd0, 32'd0);
    chk("bad_mode_err", 32'(err), 32'h1E);
    rd(2'd1, 11'h020, 4'd0, 32'h1122CCDD);
    nop(5);

    // Auto-precharge on READ closes the bank
    do_reset();
    init_seq();
    cmd(C_ACT, 2'd1, 11'd5, 4'd0, 32'd0);
    nop(3);
    cmd(C_WR, 2'd1, 11'h005, 4'd0, 32'h5A5A0005);
    rd(2'd1, 11'h405, 4'd0, 32'h5A5A0005);
    cmd(C_RD, 2'd1, 11'h005, 4'd0, 32'd0);
    nop(4);
    chk("autopre_err", 32'(err), 32'h04);

    // Reset while a beat is on the bus: oe drops at once, nothing follows
    do_reset();
    init_seq();
    cmd(C_ACT, 2'd1, 11'd5, 4'd0, 32'd0);
    nop(3);
    rd(2'd1, 11'h005, 4'd0, 32'h5A5A0005);
    @(posedge clk);
    #2;
    chk("inflight_oe", 32'(sd_dq_oe), 32'd1);
    chk("inflight_data", sd_dq_out, 32'h5A5A0005);
    sb.delete();
    reset_n = 1'b0;
    #1;
    chk("async_rst_oe", 32'(sd_dq_oe), 32'd0);
    chk("async_rst_dq", sd_dq_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    nop(6);
    chk("post_rst_ready", 32'(ready), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
